// File: rtl/jtpopeye_sdram_arb.sv
// ============================================================================
//  Module   : jtpopeye_sdram_arb
//  Purpose  : Shares one SDRAM read port between the main CPU ROM (byte reads)
//             and the object ROM (32-bit words). Each requester has a one-word
//             cache. Refresh is only allowed in idle slots. The game is held in
//             reset while the ROM downloads.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module jtpopeye_sdram_arb #(
   parameter logic [21:0] MAIN_OFFSET = 22'h00000,
   parameter logic [21:0] OBJ_OFFSET  = 22'h02000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        downloading,
   input  logic        loop_rst,
   input  logic        main_cs,
   input  logic [14:0] main_addr,
   output logic [7:0]  main_dout,
   output logic        main_ok,
   input  logic [12:0] obj_addr,
   output logic [31:0] obj_dout,
   output logic        sdram_req,
   input  logic        sdram_ack,
   input  logic        data_rdy,
   input  logic [31:0] data_read,
   output logic [21:0] sdram_addr,
   output logic        refresh_en,
   output logic        ready
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_ACK  = 2'd1;
   localparam logic [1:0] WAIT_DATA = 2'd2;

   logic [1:0]  state;
   logic        main_valid;
   logic [12:0] main_tag;
   logic [31:0] main_data;
   logic        obj_valid;
   logic [12:0] obj_tag;
   logic        gnt_obj;     // current transfer belongs to the object ROM
   logic        last_obj;    // most recent grant went to the object ROM
   logic [12:0] gnt_tag;     // word address latched when the grant was made

   logic        main_hit;
   logic        main_pend;
   logic        obj_pend;
   logic        pick_obj;
   logic [7:0]  main_byte;

   assign main_hit  = main_valid && (main_tag == main_addr[14:2]);
   assign main_pend = main_cs && !main_hit;
   assign obj_pend  = !obj_valid || (obj_tag != obj_addr);
   // Round-robin: on a tie the requester not served last wins
   assign pick_obj  = obj_pend && (!main_pend || !last_obj);

   // Byte lane selection from the cached main word (byte 0 in bits 7:0)
   always_comb begin
      main_byte = main_data[7:0];
      case (main_addr[1:0])
         2'd0:    main_byte = main_data[7:0];
         2'd1:    main_byte = main_data[15:8];
         2'd2:    main_byte = main_data[23:16];
         default: main_byte = main_data[31:24];
      endcase
   end

   // Ready rises once the controller has finished initialising after download
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready <= 1'b0;
      end else if (downloading) begin
         ready <= 1'b0;
      end else if (!loop_rst) begin
         ready <= 1'b1;
      end
   end

   // Main ROM output: registered hit flag and byte, one cycle after the inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_ok   <= 1'b0;
         main_dout <= 8'd0;
      end else if (downloading) begin
         main_ok   <= 1'b0;
         main_dout <= 8'd0;
      end else begin
         main_ok <= main_cs && main_hit;
         if (main_cs && main_hit) begin
            main_dout <= main_byte;
         end
      end
   end

   // Request sequencer: grant, wait for acceptance, wait for data, fill cache
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sdram_req  <= 1'b0;
         sdram_addr <= 22'd0;
         refresh_en <= 1'b1;
         main_valid <= 1'b0;
         main_tag   <= 13'd0;
         main_data  <= 32'd0;
         obj_valid  <= 1'b0;
         obj_tag    <= 13'd0;
         obj_dout   <= 32'd0;
         gnt_obj    <= 1'b0;
         gnt_tag    <= 13'd0;
         last_obj   <= 1'b0;
      end else if (downloading) begin
         // Abort any transfer; a late data_rdy lands in IDLE and is ignored
         state      <= IDLE;
         sdram_req  <= 1'b0;
         sdram_addr <= 22'd0;
         refresh_en <= 1'b1;
         main_valid <= 1'b0;
         obj_valid  <= 1'b0;
         obj_dout   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (main_pend || obj_pend) begin
                  gnt_obj    <= pick_obj;
                  last_obj   <= pick_obj;
                  gnt_tag    <= pick_obj ? obj_addr : main_addr[14:2];
                  sdram_addr <= pick_obj ? (OBJ_OFFSET  + {9'd0, obj_addr})
                                         : (MAIN_OFFSET + {9'd0, main_addr[14:2]});
                  sdram_req  <= 1'b1;
                  refresh_en <= 1'b0;
                  state      <= WAIT_ACK;
               end else begin
                  refresh_en <= 1'b1;
               end
            end
            WAIT_ACK: begin
               if (sdram_ack) begin
                  sdram_req <= 1'b0;
                  state     <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (data_rdy) begin
                  // The tag latched at grant is stored, so an address that moved
                  // during the transfer simply misses again afterwards
                  if (gnt_obj) begin
                     obj_valid <= 1'b1;
                     obj_tag   <= gnt_tag;
                     obj_dout  <= data_read;
                  end else begin
                     main_valid <= 1'b1;
                     main_tag   <= gnt_tag;
                     main_data  <= data_read;
                  end
                  refresh_en <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_jtpopeye_sdram_arb.sv
// ============================================================================
//  Module   : tb_jtpopeye_sdram_arb
//  Purpose  : Self-checking bench for jtpopeye_sdram_arb: SDRAM responder
//             model, directed scenarios and a randomized scoreboard phase.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_jtpopeye_sdram_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        downloading;
   logic        loop_rst;
   logic        main_cs;
   logic [14:0] main_addr;
   logic [7:0]  main_dout;
   logic        main_ok;
   logic [12:0] obj_addr;
   logic [31:0] obj_dout;
   logic        sdram_req;
   logic        sdram_ack;
   logic        data_rdy;
   logic [31:0] data_read;
   logic [21:0] sdram_addr;
   logic        refresh_en;
   logic        ready;

   int n_chk  = 0;
   int n_fail = 0;
   int fix_dly = -1;          // forced ack-to-data delay, -1 = random
   bit mon_en = 1'b0;
   logic [31:0] prev_obj = 32'd0;
   logic [21:0] req_log[$];
   logic [7:0]  main_q[$];
   logic [31:0] obj_q[$];
   logic [14:0] m_a;
   logic [12:0] o_a;
   int n0;

   jtpopeye_sdram_arb dut (
      .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
      .main_cs(main_cs), .main_addr(main_addr), .main_dout(main_dout),
      .main_ok(main_ok), .obj_addr(obj_addr), .obj_dout(obj_dout),
      .sdram_req(sdram_req), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
      .data_read(data_read), .sdram_addr(sdram_addr), .refresh_en(refresh_en),
      .ready(ready)
   );

   always #25 clk = ~clk;

   // SDRAM contents: two fixed words used by directed checks, a bijective hash elsewhere
   function automatic logic [31:0] mem_word(input logic [21:0] a);
      if (a == 22'h000001) return 32'hDDCCBBAA;
      if (a == 22'h002010) return 32'h12345678;
      return ({10'd0, a} * 32'h9E3779B1) ^ 32'h5A5AA5A5;
   endfunction

   function automatic logic [7:0] exp_byte(input logic [14:0] a);
      logic [31:0] w;
      w = mem_word(22'h000000 + {9'd0, a[14:2]});
      return w[8*a[1:0] +: 8];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_main_ok(input string nm);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (main_ok) break;
      end
      chk(nm, {31'd0, main_ok}, 32'd1);
   endtask

   task automatic wait_obj(input string nm, input logic [31:0] w);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (obj_dout == w) break;
      end
      chk(nm, obj_dout, w);
   endtask

   // SDRAM controller model: accepts a request after 0-2 cycles, returns data later
   initial begin
      logic [21:0] ra;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      data_read = 32'd0;
      forever begin
         @(negedge clk);
         if (sdram_req) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = sdram_addr;
            req_log.push_back(ra);
            sdram_ack = 1'b1;
            @(negedge clk);
            sdram_ack = 1'b0;
            repeat ((fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3))) @(negedge clk);
            data_read = mem_word(ra);
            data_rdy  = 1'b1;
            @(negedge clk);
            data_rdy  = 1'b0;
         end
      end
   end

   // Scoreboard monitor: pops an expectation whenever the DUT presents output
   initial begin
      logic [31:0] e32;
      logic [7:0]  e8;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (main_ok) begin
               if (main_q.size() == 0) chk("main_unexpected_ok", 32'd1, 32'd0);
               else begin
                  e8 = main_q.pop_front();
                  chk("main_byte", {24'd0, main_dout}, {24'd0, e8});
               end
            end
            if (obj_dout !== prev_obj) begin
               if (obj_q.size() == 0) chk("obj_unexpected_word", obj_dout, prev_obj);
               else begin
                  e32 = obj_q.pop_front();
                  chk("obj_word", obj_dout, e32);
               end
            end
         end
         prev_obj = obj_dout;
      end
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Directed scenarios followed by a randomized phase
   initial begin
      rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b1;
      main_cs = 1'b0; main_addr = 15'd0; obj_addr = 13'd0;
      repeat (2) @(negedge clk);
      chk("rst_ready",      {31'd0, ready},      32'd0);
      chk("rst_sdram_req",  {31'd0, sdram_req},  32'd0);
      chk("rst_refresh_en", {31'd0, refresh_en}, 32'd1);
      chk("rst_main_ok",    {31'd0, main_ok},    32'd0);
      chk("rst_main_dout",  {24'd0, main_dout},  32'd0);
      chk("rst_obj_dout",   obj_dout,            32'd0);
      chk("rst_sdram_addr", {10'd0, sdram_addr}, 32'd0);

      // Release reset into a download with both requesters already missing
      rst_n = 1'b1; downloading = 1'b1;
      main_cs = 1'b1; main_addr = 15'h0005; obj_addr = 13'h0010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("dl_ready", {31'd0, ready},     32'd0);
         chk("dl_req",   {31'd0, sdram_req}, 32'd0);
      end
      downloading = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("loop_rst_ready", {31'd0, ready}, 32'd0);
      end
      loop_rst = 1'b0;
      @(negedge clk);
      chk("ready_rise", {31'd0, ready}, 32'd1);

      // First tie from reset: obj wins, then main
      wait_main_ok("tie1_main_ok");
      chk("tie1_main_dout", {24'd0, main_dout}, 32'hBB);
      chk("tie1_req_count", req_log.size(), 32'd2);
      if (req_log.size() >= 2) begin
         chk("tie1_first_obj",   {10'd0, req_log[0]}, 32'h002010);
         chk("tie1_second_main", {10'd0, req_log[1]}, 32'h000001);
      end
      chk("obj_word_0010", obj_dout, 32'h12345678);

      // Same-word hit: one cycle, no SDRAM traffic
      n0 = req_log.size();
      main_addr = 15'h0007;
      @(negedge clk);
      chk("hit_main_ok",   {31'd0, main_ok},   32'd1);
      chk("hit_main_dout", {24'd0, main_dout}, 32'hDD);
      chk("hit_no_req",    {31'd0, sdram_req}, 32'd0);
      repeat (5) @(negedge clk);
      chk("held_no_req", req_log.size(), n0);
      main_cs = 1'b0;
      @(negedge clk);
      chk("cs_low_ok0", {31'd0, main_ok}, 32'd0);
      chk("idle_refresh", {31'd0, refresh_en}, 32'd1);

      // Lone obj fetch: refresh blocked during the transfer
      obj_addr = 13'h0020;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sdram_req) break;
      end
      chk("xfer_req", {31'd0, sdram_req}, 32'd1);
      chk("xfer_refresh_off", {31'd0, refresh_en}, 32'd0);
      wait_obj("obj_word_0020", mem_word(22'h002020));
      @(negedge clk);
      chk("post_refresh_on", {31'd0, refresh_en}, 32'd1);

      // Second tie after an obj grant: main wins this time
      n0 = req_log.size();
      main_cs = 1'b1; main_addr = 15'h0100; obj_addr = 13'h0030;
      wait_main_ok("tie2_main_ok");
      chk("tie2_main_dout", {24'd0, main_dout}, {24'd0, exp_byte(15'h0100)});
      wait_obj("tie2_obj_word", mem_word(22'h002030));
      chk("tie2_req_count", req_log.size(), n0 + 2);
      if (req_log.size() >= n0 + 2) begin
         chk("tie2_first_main", {10'd0, req_log[n0]},     32'h000040);
         chk("tie2_second_obj", {10'd0, req_log[n0 + 1]}, 32'h002030);
      end
      main_cs = 1'b0;
      @(negedge clk);

      // Address changes in the same cycle as data_rdy: old tag stored, new one misses
      main_cs = 1'b1; main_addr = 15'h0200;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (data_rdy) break;
      end
      main_addr = 15'h0300;
      @(negedge clk);
      chk("swap_ok0_a", {31'd0, main_ok}, 32'd0);
      @(negedge clk);
      chk("swap_ok0_b", {31'd0, main_ok}, 32'd0);
      wait_main_ok("swap_refetch_ok");
      chk("swap_dout", {24'd0, main_dout}, {24'd0, exp_byte(15'h0300)});
      chk("swap_req_addr", {10'd0, req_log[$]}, 32'h0000C0);
      main_cs = 1'b0;
      @(negedge clk);

      // Download asserted in WAIT_DATA: abort, stray data_rdy ignored
      fix_dly = 6;
      obj_addr = 13'h0040;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (sdram_ack) break;
      end
      chk("abort_ack_seen", {31'd0, sdram_ack}, 32'd1);
      @(negedge clk);
      downloading = 1'b1;
      @(negedge clk);
      chk("abort_req0",    {31'd0, sdram_req},  32'd0);
      chk("abort_refresh", {31'd0, refresh_en}, 32'd1);
      chk("abort_ready0",  {31'd0, ready},      32'd0);
      repeat (8) @(negedge clk);
      chk("stray_obj_dout",  obj_dout,           32'd0);
      chk("stray_main_dout", {24'd0, main_dout}, 32'd0);
      downloading = 1'b0; fix_dly = -1;
      main_cs = 1'b1; main_addr = 15'h0300;
      @(negedge clk);
      chk("cleared_main_miss", {31'd0, main_ok}, 32'd0);
      chk("cleared_obj_dout",  obj_dout,         32'd0);
      wait_main_ok("refill_main_ok");
      chk("refill_main_dout", {24'd0, main_dout}, {24'd0, exp_byte(15'h0300)});
      wait_obj("refill_obj_word", mem_word(22'h002040));
      chk("ready_again", {31'd0, ready}, 32'd1);
      main_cs = 1'b0;
      repeat (2) @(negedge clk);

      // Randomized phase, checked by the scoreboard monitor
      mon_en = 1'b1;
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               if ($urandom_range(0, 1) == 1) m_a = {main_addr[14:2], 2'($urandom_range(0, 3))};
               else                           m_a = 15'($urandom);
               if (m_a == main_addr || $urandom_range(0, 3) == 0) begin
                  main_cs = 1'b0;
                  repeat ($urandom_range(1, 2)) @(negedge clk);
                  #1;
               end
               main_q.push_back(exp_byte(m_a));
               main_addr = m_a;
               main_cs   = 1'b1;
               for (int i = 0; i < 300; i++) begin
                  @(negedge clk); #1;
                  if (main_q.size() == 0) break;
               end
               if (main_q.size() != 0) begin
                  chk("main_timeout", main_q.size(), 32'd0);
                  main_q.delete();
               end
            end
            main_cs = 1'b0;
         end
         begin
            for (int k = 0; k < 25; k++) begin
               o_a = 13'($urandom);
               if (o_a == obj_addr) o_a = o_a ^ 13'd1;
               obj_q.push_back(mem_word(22'h002000 + {9'd0, o_a}));
               obj_addr = o_a;
               for (int i = 0; i < 300; i++) begin
                  @(negedge clk); #1;
                  if (obj_q.size() == 0) break;
               end
               if (obj_q.size() != 0) begin
                  chk("obj_timeout", obj_q.size(), 32'd0);
                  obj_q.delete();
               end
               repeat ($urandom_range(0, 4)) @(negedge clk);
            end
         end
      join
      repeat (3) @(negedge clk);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
